rf_port_master: RTL and testbench
=================================

RF_PORT_MASTER -- requirements
Module: rf_port_master

Interface
REQ-001 Parameter DW, default 32, register and data width.
REQ-002 Parameter AW, default 4, register index width (16 registers).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  pipeline request valid.
REQ-006 req_ready  out  1  request accepted when req_valid & req_ready at a rising edge.
REQ-007 req_op  in  2  00 READ, 01 WR_LO, 10 WR_HI, 11 WR_FULL.
REQ-008 req_ra, req_rb  in  AW each  read indices for READ.
REQ-009 req_wa  in  AW  write index for WR_*.
REQ-010 req_wdata  in  DW  write data for WR_*.
REQ-011 rsp_valid  out  1  read response valid.
REQ-012 rsp_ready  in  1  consumer accepts response.
REQ-013 rsp_data1, rsp_data2  out  DW each  read results.
REQ-014 wr_done  out  1  one-cycle pulse when a write completes.
REQ-015 err  out  1  one-cycle pulse on an unsupported op.
REQ-016 rf_reg_port1, rf_reg_port2, rf_write_reg  out  AW each  register-file index ports.
REQ-017 rf_data_in  out  DW  register-file write data.
REQ-018 rf_we  out  1  register-file write enable; 0 = read/capture cycle.
REQ-019 rf_hl  out  1  1 = write upper half, 0 = write lower half.
REQ-020 rf_reg_out1, rf_reg_out2  in  DW each  register-file read data, valid one cycle after a capture cycle.

Function
REQ-021 The FSM SHALL have states IDLE, RD, RSP, PREP, WR, PREP2, WR2.
REQ-022 req_ready SHALL be 1 only in IDLE; requests are sampled only in IDLE.
REQ-023 READ accept: IDLE->RD; in RD, rf_we=0, rf_reg_port1=ra, rf_reg_port2=rb.
REQ-024 RD->RSP; in RSP, rsp_valid=1 and rsp_data1/2 hold the rf_reg_out1/2 values captured on entry to RSP. rsp_valid therefore rises 2 cycles after acceptance.
REQ-025 RSP SHALL hold rsp_valid and the data stable until rsp_ready=1, then go to IDLE.
REQ-026 WR_LO/WR_HI accept: IDLE->PREP. In PREP, rf_we=0 and rf_write_reg=wa, so the RF loads its merge register.
REQ-027 PREP->WR. In WR, rf_we=1, rf_write_reg=wa, rf_data_in=wdata, rf_hl=1 for WR_HI and 0 for WR_LO.
REQ-028 WR->IDLE with wr_done=1 for exactly the cycle after WR.
REQ-029 WR_FULL (with macro): PREP->WR (rf_hl=1)->PREP2->WR2 (rf_hl=0)->IDLE. wr_done pulses once, after WR2. Both halves come from the same wdata.
REQ-030 Request fields SHALL be latched at acceptance; input changes during an operation have no effect.
REQ-031 Outside RD/PREP/WR/PREP2/WR2, rf_we=0 and all index outputs hold their last value.
REQ-032 A write to wa immediately followed by a READ of wa SHALL return the new value, with no forwarding; this is guaranteed by sequencing.

Reset
REQ-033 reset SHALL force IDLE immediately, including mid-operation.
REQ-034 On reset, all outputs SHALL be 0 except req_ready, which is 1. This covers rf_we, rf_hl, rsp_valid, wr_done, err, and every index and data output.
REQ-035 An operation interrupted by reset SHALL be dropped, with no wr_done and no rsp_valid.

Configuration
REQ-036 Macro RF_PORT_MASTER_FULLWORD_EN: when defined, WR_FULL SHALL execute per REQ-029.
REQ-037 When the macro is undefined, WR_FULL SHALL be accepted, drive no RF activity, pulse err the next cycle, and return to IDLE. States PREP2/WR2 are absent.

Structure
REQ-038 Package rf_port_master_pkg SHALL hold the op encodings and the FSM state encoding.
REQ-039 No sub-module is needed; a single module with one registered FSM and registered outputs is sufficient.

Verification
REQ-040 Preload R3=0x11112222 and R5=0xAAAABBBB; READ ra=3, rb=5. Required: rsp_valid at acceptance+2, rsp_data1=0x11112222, rsp_data2=0xAAAABBBB.
REQ-041 R7=0x12345678; WR_HI wa=7, wdata=0xDEAD0000; READ 7. Required: 0xDEAD5678, wr_done pulse, rf_we high exactly one cycle.
REQ-042 R7=0x12345678; WR_LO wdata=0x0000BEEF; READ 7. Required: 0x1234BEEF.
REQ-043 WR_FULL wa=2, wdata=0xCAFEF00D. With the macro: READ 2 returns 0xCAFEF00D after 4 busy cycles. Without the macro: err pulse, R2 unchanged.
REQ-044 READ with rsp_ready held 0 for 5 cycles. Required: rsp_valid and data stable throughout, req_ready=0 until the handshake completes.
REQ-045 Assert reset during WR_HI PREP. Required: FSM in IDLE, rf_we never asserted, no wr_done, target register unchanged.

Source files
------------

// File: rtl/rf_port_master_pkg.sv
// Op and FSM encodings for the register-file port master.
// RF_PORT_MASTER_FULLWORD_EN adds the PREP2/WR2 full-word states.
package rf_port_master_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WR_LO   = 2'b01,
    OP_WR_HI   = 2'b10,
    OP_WR_FULL = 2'b11
  } op_e;

`ifdef RF_PORT_MASTER_FULLWORD_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_RSP   = 3'd2,
    S_PREP  = 3'd3,
    S_WR    = 3'd4,
    S_PREP2 = 3'd5,
    S_WR2   = 3'd6
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RSP  = 3'd2,
    S_PREP = 3'd3,
    S_WR   = 3'd4
  } state_e;
`endif

endpackage

// File: rtl/rf_port_master_if.sv
// Request/response handshake and register-file bus of rf_port_master.
// Shared by all builds; RF_PORT_MASTER_FULLWORD_EN does not change it.
interface rf_port_master_if
  import rf_port_master_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
);

  logic          req_valid;
  logic          req_ready;
  op_e           req_op;
  logic [AW-1:0] req_ra;
  logic [AW-1:0] req_rb;
  logic [AW-1:0] req_wa;
  logic [DW-1:0] req_wdata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data1;
  logic [DW-1:0] rsp_data2;
  logic          wr_done;
  logic          err;

  logic [AW-1:0] rf_reg_port1;
  logic [AW-1:0] rf_reg_port2;
  logic [AW-1:0] rf_write_reg;
  logic [DW-1:0] rf_data_in;
  logic          rf_we;
  logic          rf_hl;
  logic [DW-1:0] rf_reg_out1;
  logic [DW-1:0] rf_reg_out2;

  modport master (
    input  req_valid, req_op, req_ra, req_rb,
    input  req_wa, req_wdata, rsp_ready,
    input  rf_reg_out1, rf_reg_out2,
    output req_ready, rsp_valid,
    output rsp_data1, rsp_data2,
    output wr_done, err,
    output rf_reg_port1, rf_reg_port2,
    output rf_write_reg, rf_data_in,
    output rf_we, rf_hl
  );

  modport slave (
    output req_valid, req_op, req_ra, req_rb,
    output req_wa, req_wdata, rsp_ready,
    output rf_reg_out1, rf_reg_out2,
    input  req_ready, rsp_valid,
    input  rsp_data1, rsp_data2,
    input  wr_done, err,
    input  rf_reg_port1, rf_reg_port2,
    input  rf_write_reg, rf_data_in,
    input  rf_we, rf_hl
  );

endinterface

// File: rtl/rf_port_master.sv
// Sequences reads and half/full-word writes onto a merging register file.
// RF_PORT_MASTER_FULLWORD_EN enables WR_FULL; otherwise WR_FULL raises err.
module rf_port_master
  import rf_port_master_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input logic              clk,
  input logic              reset,
  rf_port_master_if.master bus
);

  state_e state, next;
  op_e    op_q;

  logic accept, done_n, err_n, hl_n, we_n;

  logic          ready_q, rsp_valid_q;
  logic          wr_done_q, err_q;
  logic          we_q, hl_q;
  logic [DW-1:0] d1_q, d2_q, wdata_q;
  logic [AW-1:0] p1_q, p2_q, wa_q;

  assign accept = (state == S_IDLE) && bus.req_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  always_comb begin
    next   = state;
    done_n = 1'b0;
    err_n  = 1'b0;
    hl_n   = hl_q;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            bus.req_op == OP_READ:  next = S_RD;
            bus.req_op == OP_WR_LO: next = S_PREP;
            bus.req_op == OP_WR_HI: next = S_PREP;
`ifdef RF_PORT_MASTER_FULLWORD_EN
            bus.req_op == OP_WR_FULL: next = S_PREP;
`else
            bus.req_op == OP_WR_FULL: err_n = 1'b1;
`endif
            default: ;
          endcase
        end
      end
      S_RD: next = S_RSP;
      S_RSP: begin
        if (rsp_valid_q && bus.rsp_ready)
          next = S_IDLE;
      end
      S_PREP: begin
        next = S_WR;
        hl_n = (op_q != OP_WR_LO);
      end
      S_WR: begin
`ifdef RF_PORT_MASTER_FULLWORD_EN
        if (op_q == OP_WR_FULL) begin
          next = S_PREP2;
        end else begin
          next   = S_IDLE;
          done_n = 1'b1;
        end
`else
        next   = S_IDLE;
        done_n = 1'b1;
`endif
      end
`ifdef RF_PORT_MASTER_FULLWORD_EN
      S_PREP2: begin
        next = S_WR2;
        hl_n = 1'b0;
      end
      S_WR2: begin
        next   = S_IDLE;
        done_n = 1'b1;
      end
`endif
      default: next = S_IDLE;
    endcase
  end

`ifdef RF_PORT_MASTER_FULLWORD_EN
  assign we_n = (next == S_WR) || (next == S_WR2);
`else
  assign we_n = (next == S_WR);
`endif

  // Index/data registers load at acceptance so the RF sees
  // them during the capture cycle that follows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= OP_READ;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      wr_done_q   <= 1'b0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      hl_q        <= 1'b0;
      d1_q        <= '0;
      d2_q        <= '0;
      wdata_q     <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      wa_q        <= '0;
    end else begin
      ready_q   <= (next == S_IDLE);
      wr_done_q <= done_n;
      err_q     <= err_n;
      we_q      <= we_n;
      hl_q      <= hl_n;
      if (accept) begin
        op_q <= bus.req_op;
        if (bus.req_op == OP_READ) begin
          p1_q <= bus.req_ra;
          p2_q <= bus.req_rb;
        end
        if (next == S_PREP) begin
          wa_q    <= bus.req_wa;
          wdata_q <= bus.req_wdata;
        end
      end
      // RF data is valid one cycle into RSP; latch it then.
      if (state == S_RSP && !rsp_valid_q) begin
        rsp_valid_q <= 1'b1;
        d1_q        <= bus.rf_reg_out1;
        d2_q        <= bus.rf_reg_out2;
      end else if (rsp_valid_q && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data1    = d1_q;
  assign bus.rsp_data2    = d2_q;
  assign bus.wr_done      = wr_done_q;
  assign bus.err          = err_q;
  assign bus.rf_reg_port1 = p1_q;
  assign bus.rf_reg_port2 = p2_q;
  assign bus.rf_write_reg = wa_q;
  assign bus.rf_data_in   = wdata_q;
  assign bus.rf_we        = we_q;
  assign bus.rf_hl        = hl_q;

endmodule

// File: tb/tb_rf_port_master.sv
// Bench for rf_port_master: merging RF model plus a per-cycle scoreboard.
// Expectations follow RF_PORT_MASTER_FULLWORD_EN when it is defined.
module tb_rf_port_master;
  import rf_port_master_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int H    = DW / 2;
  localparam int MAXC = 8192;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  rf_port_master_if #(.DW(DW), .AW(AW)) bus ();

  rf_port_master #(.DW(DW), .AW(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file with a merge register reloaded on every non-write cycle.
  logic [DW-1:0] rf_mem [16];
  logic [DW-1:0] merge, out1, out2;
  logic          pl_en;
  logic [AW-1:0] pl_a;
  logic [DW-1:0] pl_d;

  always @(posedge clk) begin
    if (pl_en) begin
      rf_mem[pl_a] <= pl_d;
    end else if (bus.rf_we) begin
      if (bus.rf_hl)
        rf_mem[bus.rf_write_reg] <= {bus.rf_data_in[DW-1:H], merge[H-1:0]};
      else
        rf_mem[bus.rf_write_reg] <= {merge[DW-1:H], bus.rf_data_in[H-1:0]};
    end else begin
      out1  <= rf_mem[bus.rf_reg_port1];
      out2  <= rf_mem[bus.rf_reg_port2];
      merge <= rf_mem[bus.rf_write_reg];
    end
  end

  assign bus.rf_reg_out1 = out1;
  assign bus.rf_reg_out2 = out2;

  // Expected outputs indexed by the number of rising edges seen so far.
  bit            e_ready [MAXC];
  bit            e_rv    [MAXC];
  bit            e_done  [MAXC];
  bit            e_err   [MAXC];
  bit            e_we    [MAXC];
  logic [DW-1:0] e_d1    [MAXC];
  logic [DW-1:0] e_d2    [MAXC];

  logic [DW-1:0] mdl [16];
  int free_at;

  typedef struct {
    string         name;
    logic [DW-1:0] act;
    logic [DW-1:0] exp;
  } pin_t;
  pin_t pin_q[$];

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string n,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_ctl", 64'({bus.rsp_valid, bus.wr_done, bus.err,
                           bus.rf_we, bus.rf_hl}), 64'd0);
      chk("rst_idx", 64'({bus.rf_reg_port1, bus.rf_reg_port2,
                           bus.rf_write_reg}), 64'd0);
      chk("rst_data", 64'(bus.rf_data_in | bus.rsp_data1 | bus.rsp_data2),
          64'd0);
    end else if (cyc < MAXC) begin
      chk("req_ready", 64'(bus.req_ready), 64'(e_ready[cyc]));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(e_rv[cyc]));
      chk("wr_done",   64'(bus.wr_done),   64'(e_done[cyc]));
      chk("err",       64'(bus.err),       64'(e_err[cyc]));
      chk("rf_we",     64'(bus.rf_we),     64'(e_we[cyc]));
      if (e_rv[cyc]) begin
        chk("rsp_data1", 64'(bus.rsp_data1), 64'(e_d1[cyc]));
        chk("rsp_data2", 64'(bus.rsp_data2), 64'(e_d2[cyc]));
      end
    end
    while (pin_q.size() > 0) begin
      pin_t p;
      p = pin_q.pop_front();
      chk(p.name, 64'(p.act), 64'(p.exp));
    end
  end

  task automatic wait_free();
    while (cyc < free_at) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_free();
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    mdl[a] = d;
    @(posedge clk);
    #2;
    pl_en = 1'b0;
    free_at = cyc;
  endtask

  task automatic scramble();
    logic [1:0] t;
    t = 2'($urandom_range(0, 3));
    bus.req_op    = op_e'(t);
    bus.req_ra    = AW'($urandom);
    bus.req_rb    = AW'($urandom);
    bus.req_wa    = AW'($urandom);
    bus.req_wdata = $urandom;
  endtask

  task automatic issue(input op_e op,
                       input logic [AW-1:0] ra, rb, wa,
                       input logic [DW-1:0] wd,
                       input int hold,
                       output logic [DW-1:0] d1, d2);
    int a;
    d1 = '0;
    d2 = '0;
    wait_free();
    bus.req_op    = op;
    bus.req_ra    = ra;
    bus.req_rb    = rb;
    bus.req_wa    = wa;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #2;
    a = cyc;
    bus.req_valid = 1'b0;
    scramble();
    case (op)
      OP_READ: begin
        for (int c = a; c <= a + 2 + hold; c++) e_ready[c] = 1'b0;
        for (int c = a + 2; c <= a + 2 + hold; c++) begin
          e_rv[c] = 1'b1;
          e_d1[c] = mdl[ra];
          e_d2[c] = mdl[rb];
        end
        free_at = a + 3 + hold;
        for (int c = a; c <= a + 2 + hold; c++) begin
          if (c < a + 2) bus.rsp_ready = 1'($urandom);
          else           bus.rsp_ready = (c == a + 2 + hold);
          if (c == a + 2) begin
            d1 = bus.rsp_data1;
            d2 = bus.rsp_data2;
          end
          @(posedge clk);
          #2;
        end
        bus.rsp_ready = 1'b0;
      end
      OP_WR_LO, OP_WR_HI: begin
        e_ready[a]     = 1'b0;
        e_ready[a + 1] = 1'b0;
        e_we[a + 1]    = 1'b1;
        e_done[a + 2]  = 1'b1;
        if (op == OP_WR_HI) mdl[wa] = {wd[DW-1:H], mdl[wa][H-1:0]};
        else                mdl[wa] = {mdl[wa][DW-1:H], wd[H-1:0]};
        free_at = a + 2;
      end
      default: begin
`ifdef RF_PORT_MASTER_FULLWORD_EN
        for (int c = a; c <= a + 3; c++) e_ready[c] = 1'b0;
        e_we[a + 1]   = 1'b1;
        e_we[a + 3]   = 1'b1;
        e_done[a + 4] = 1'b1;
        mdl[wa] = wd;
        free_at = a + 4;
`else
        e_err[a] = 1'b1;
        free_at = a + 1;
`endif
      end
    endcase
  endtask

  // WR_HI accepted, then reset lands in PREP; nothing may reach the RF.
  task automatic reset_in_prep(input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd);
    wait_free();
    bus.req_op    = OP_WR_HI;
    bus.req_wa    = wa;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #2;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    reset = 1'b0;
    free_at = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d1, d2;
    logic [DW-1:0] full_exp;
    for (int i = 0; i < MAXC; i++) begin
      e_ready[i] = 1'b1;
      e_rv[i]    = 1'b0;
      e_done[i]  = 1'b0;
      e_err[i]   = 1'b0;
      e_we[i]    = 1'b0;
      e_d1[i]    = '0;
      e_d2[i]    = '0;
    end
    free_at       = 0;
    pl_en         = 1'b0;
    pl_a          = '0;
    pl_d          = '0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;

    for (int i = 0; i < 16; i++) preload(AW'(i), $urandom);

    preload(4'd3, 32'h11112222);
    preload(4'd5, 32'hAAAABBBB);
    issue(OP_READ, 4'd3, 4'd5, 4'd0, '0, 0, d1, d2);
    pin_q.push_back('{"read_d1", d1, 32'h11112222});
    pin_q.push_back('{"read_d2", d2, 32'hAAAABBBB});

    preload(4'd7, 32'h12345678);
    issue(OP_WR_HI, 4'd0, 4'd0, 4'd7, 32'hDEAD0000, 0, d1, d2);
    issue(OP_READ, 4'd7, 4'd7, 4'd0, '0, 0, d1, d2);
    pin_q.push_back('{"wr_hi", d1, 32'hDEAD5678});

    preload(4'd7, 32'h12345678);
    issue(OP_WR_LO, 4'd0, 4'd0, 4'd7, 32'h0000BEEF, 0, d1, d2);
    issue(OP_READ, 4'd7, 4'd3, 4'd0, '0, 1, d1, d2);
    pin_q.push_back('{"wr_lo", d1, 32'h1234BEEF});

    preload(4'd2, 32'h01020304);
    issue(OP_WR_FULL, 4'd0, 4'd0, 4'd2, 32'hCAFEF00D, 0, d1, d2);
    issue(OP_READ, 4'd2, 4'd5, 4'd0, '0, 0, d1, d2);
`ifdef RF_PORT_MASTER_FULLWORD_EN
    full_exp = 32'hCAFEF00D;
`else
    full_exp = 32'h01020304;
`endif
    pin_q.push_back('{"wr_full", d1, full_exp});

    issue(OP_READ, 4'd3, 4'd5, 4'd0, '0, 5, d1, d2);
    pin_q.push_back('{"hold_d1", d1, 32'h11112222});
    pin_q.push_back('{"hold_d2", d2, 32'hAAAABBBB});

    preload(4'd7, 32'h0BADF00D);
    reset_in_prep(4'd7, 32'hDEAD0000);
    issue(OP_READ, 4'd7, 4'd7, 4'd0, '0, 0, d1, d2);
    pin_q.push_back('{"reset_drop", d1, 32'h0BADF00D});

    for (int n = 0; n < 200; n++) begin
      logic [1:0] t;
      t = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0)
        preload(AW'($urandom), $urandom);
      issue(op_e'(t), AW'($urandom), AW'($urandom), AW'($urandom),
            $urandom, $urandom_range(0, 3), d1, d2);
    end

    wait_free();
    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
